// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// result presented for one cycle as a register file write request.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_addr,
  output logic        busy,
  output logic        done,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic [31:0] r_a_mag;
  logic [31:0] r_b_mag;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_neg;
  logic        r_rem_neg;
  logic [5:0]  r_cnt;

  // Operand decode at acceptance time
  logic        w_accept;
  logic        w_is_div;
  logic        w_div_signed;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_special;

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_is_div     = funct3[2];
  assign w_div_signed = ~funct3[0];
  assign w_a_signed   = w_is_div ? w_div_signed
                                 : ((funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10));
  assign w_b_signed   = w_is_div ? w_div_signed : (funct3[1:0] == 2'b01);
  assign w_a_neg      = w_a_signed & rs1_val[31];
  assign w_b_neg      = w_b_signed & rs2_val[31];
  assign w_a_mag      = w_a_neg ? (32'd0 - rs1_val) : rs1_val;
  assign w_b_mag      = w_b_neg ? (32'd0 - rs2_val) : rs2_val;
  assign w_div_zero   = w_is_div && (rs2_val == 32'd0);
  assign w_div_ovf    = w_is_div && w_div_signed &&
                        (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
  assign w_special    = w_div_zero || w_div_ovf;

  // One iteration: multiply shifts {carry,hi,lo} right; divide shifts {hi,lo} left
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_shift;
  logic [31:0] w_div_diff;
  logic        w_div_ok;
  logic [31:0] w_hi_step;
  logic [31:0] w_lo_step;

  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a_mag} : 33'd0);
  assign w_div_shift = {r_hi, r_lo[31]};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_b_mag});
  assign w_div_diff  = w_div_shift[31:0] - r_b_mag;

  always_comb begin
    w_hi_step = r_hi;
    w_lo_step = r_lo;
    if (r_op[2]) begin
      w_hi_step = w_div_ok ? w_div_diff : w_div_shift[31:0];
      w_lo_step = {r_lo[30:0], w_div_ok};
    end else begin
      w_hi_step = w_mul_sum[32:1];
      w_lo_step = {w_mul_sum[0], r_lo[31:1]};
    end
  end

  // Sign fix-up of the final magnitudes
  logic [63:0] w_prod;
  logic [63:0] w_prod_s;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_result;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? (64'd0 - w_prod) : w_prod;
  assign w_quot   = r_neg ? (32'd0 - r_lo) : r_lo;
  assign w_rem    = r_rem_neg ? (32'd0 - r_hi) : r_hi;

  always_comb begin
    w_result = 32'd0;
    case (r_op)
      3'b000:                 w_result = w_prod_s[31:0];
      3'b001, 3'b010, 3'b011: w_result = w_prod_s[63:32];
      3'b100, 3'b101:         w_result = w_quot;
      default:                w_result = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    we           = 1'b0;
    wa           = 5'd0;
    wd           = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == 6'd31) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        we           = (r_rd != 5'd0);
        wa           = r_rd;
        wd           = w_result;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= 3'd0;
      r_rd      <= 5'd0;
      r_a_mag   <= 32'd0;
      r_b_mag   <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_cnt     <= 6'd0;
    end else if (w_accept) begin
      r_op    <= funct3;
      r_rd    <= rd_addr;
      r_a_mag <= w_a_mag;
      r_b_mag <= w_b_mag;
      r_cnt   <= 6'd0;
      // Special cases preload the final registers so the normal fix-up yields the RISC-V value
      if (w_div_zero) begin
        r_lo      <= 32'hFFFF_FFFF;
        r_hi      <= rs1_val;
        r_neg     <= 1'b0;
        r_rem_neg <= 1'b0;
      end else if (w_div_ovf) begin
        r_lo      <= 32'h8000_0000;
        r_hi      <= 32'd0;
        r_neg     <= 1'b0;
        r_rem_neg <= 1'b0;
      end else if (w_is_div) begin
        r_lo      <= w_a_mag;
        r_hi      <= 32'd0;
        r_neg     <= w_a_neg ^ w_b_neg;
        r_rem_neg <= w_a_neg;
      end else begin
        r_lo      <= w_b_mag;
        r_hi      <= 32'd0;
        r_neg     <= w_a_neg ^ w_b_neg;
        r_rem_neg <= 1'b0;
      end
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 6'd1;
      r_hi  <= w_hi_step;
      r_lo  <= w_lo_step;
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit for the core. It takes the two register operands read from the register file, computes the M-extension result over multiple cycles and returns it as a single-cycle write request on the register file write port (`we3`/`a3`/`wd3`). While it is busy, `busy` stalls the issue logic.

## Interface
Parameters: none. The datapath is fixed at 32 bits.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `start`  in  1  request a new operation; accepted only while `busy`=0.
- `funct3`  in  3  opcode select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_val`  in  32  operand A (multiplicand or dividend).
- `rs2_val`  in  32  operand B (multiplier or divisor).
- `rd_addr`  in  5  destination register.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `we`  out  1  register file write enable; drives `we3`.
- `wa`  out  5  write address; drives `a3`.
- `wd`  out  32  write data; drives `wd3`.

## Operation
- **States: IDLE, CALC, DONE.**
  - IDLE + `start`: latch `funct3`, operands and `rd_addr`; clear the 6-bit iteration counter.
    - If the divide is by zero or is the signed overflow case, go to DONE.
    - Otherwise go to CALC.
  - CALC: perform one iteration per cycle. After the 32nd iteration, go to DONE.
  - DONE: assert `done` and drive the result. Go to IDLE on the next edge.
- `start` is ignored in CALC and DONE; there is no queueing. Operand input changes after acceptance have no effect.
- **Multiply:** radix-2 shift-add on magnitudes, producing a 64-bit product.
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU: both operands unsigned.
  - The product is negated when exactly one signed-treated operand is negative.
  - MUL returns bits [31:0]; the MULH variants return bits [63:32].
- **Divide:** restoring division on magnitudes.
  - Signed quotient is negative when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- **Special cases (RISC-V defined):**
  - Divisor = 0:
    - DIV and DIVU return 0xFFFFFFFF.
    - REM and REMU return the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF returns 0x80000000.
  - REM with the same operands returns 0.
- **Write-back:** `we` = 1 in DONE only when the latched `rd_addr` != 0. `done` pulses regardless of `rd_addr`. `wa` equals the latched `rd_addr`.
- **Output values:**
  - In DONE: `done` = 1, `wd` = result, `wa` = latched `rd_addr`.
  - In all other states: `done` = `we` = 0, `wa` = 0, `wd` = 0.

## Timing
- **Reset:** state goes to IDLE; `busy`, `done`, `we` = 0; `wa` = 0; `wd` = 0; all internal registers are cleared.
- **Reset mid-operation:** the next cycle is IDLE with no `done` and no write. A `start` that is high in the same cycle as `reset` is dropped.
- **Normal latency:**
  - Cycle 0: `start` is accepted at the end of cycle 0.
  - Cycles 1–32: CALC, `busy` = 1.
  - Cycle 33: DONE, with `done`/`we`/`wd` valid.
  - Cycle 34: IDLE; a new `start` can be accepted in this cycle.
- **Special-case latency:** DONE is in cycle 1 and IDLE in cycle 2.
- **Busy window:** `busy` is high from the cycle after acceptance through the DONE cycle inclusive. It is combinational from the state register.
- **Register file interaction:** the register file captures `wd` at the end of the DONE cycle. A read of that register returns the new value from the following cycle. This unit does not forward.

## Test plan
- MUL 7 × 0xFFFFFFFD (rd = 5), with `start` in cycle 0 → `busy` high in cycles 1–33; cycle 33 has `done` = `we` = 1, `wa` = 5, `wd` = 0xFFFFFFEB; cycle 34 is idle.
- High products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Signed divide:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- Special cases:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5, with `done` in cycle 1.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, with `done` in cycle 1.
  - REM with the same operands → 0.
- Start handling and x0:
  - A second `start` during CALC is ignored and only one `done` pulse occurs.
  - `rd_addr` = 0 → `done` = 1 with `we` = 0.
  - Operands changed in cycle 2 → the result is unchanged.
- Reset:
  - `reset` asserted in cycle 10 of a DIV → cycle 11 has `busy` = 0, and no `done`/`we` ever appears.
  - A new MUL started afterwards completes correctly 33 cycles after acceptance.
